// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multicycle processor: opcodes, ALU
// operation encodings and the control FSM state type.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM_READ,
    MEM_WRITE,
    WRITEBACK,
    PC_UPDATE,
    HALT
  } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Memory port of the multicycle processor. The controller is the master
// (requester); the memory is the slave.
interface multicycle_control_if #(parameter int WIDTH = 16);

  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;
  logic             MemRead;
  logic             MemWrite;
  logic             mem_addr_sel;

  modport master (
    input  mem_rdata, mem_ready,
    output MemRead, MemWrite, mem_addr_sel
  );

  modport slave (
    output mem_rdata, mem_ready,
    input  MemRead, MemWrite, mem_addr_sel
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait timer: a down-counter reloaded on restart; expired flags the
// MEM_TIMEOUT-th consecutive cycle spent in a memory state.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic expired
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LOAD = TW'(MEM_TIMEOUT - 1);

  logic [TW-1:0] cnt;

  // Reload on restart, otherwise count down and hold at terminal count.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the 16-bit multicycle processor.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   FETCH     | read instruction from memory (address from PC)
//   DECODE    | register file produces rd1/rd2, no strobes
//   EXECUTE   | ALU operation, branch condition captured
//   MEM_READ  | LW data access (address from ALU)
//   MEM_WRITE | SW data access (address from ALU)
//   WRITEBACK | register-file write
//   PC_UPDATE | PC write, instruction retired
//   HALT      | stopped until reset (HALT opcode or bus error)
import cpu_pkg::*;

module multicycle_control #(
  parameter int WIDTH       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   mem,
  input  logic                   alu_zero,
  output logic [WIDTH-1:0]       instruction,
  output logic                   RegWrite,
  output logic                   PCWrite,
  output logic [1:0]             alu_op,
  output logic                   alu_src_imm,
  output logic                   wb_sel,
  output logic                   pc_src,
  output logic                   illegal,
  output logic                   bus_err,
  output logic                   halted,
  output logic [CNT_W-1:0]       instr_count
);

  state_t     state, state_nxt;
  logic [3:0] opcode;
  logic       taken;
  logic       expired;
  logic       restart;
  logic       in_mem;
  logic       timed_out;

  assign opcode    = instruction[WIDTH-1:WIDTH-4];
  assign in_mem    = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  assign timed_out = in_mem && !mem.mem_ready && expired;
  assign restart   = (state_nxt != state);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Instruction register, branch flag, retire counter and sticky bus error.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= '0;
      taken       <= 1'b0;
      instr_count <= '0;
      bus_err     <= 1'b0;
    end else begin
      if (state == FETCH && mem.mem_ready) instruction <= mem.mem_rdata;
      if (state == EXECUTE && opcode == OP_BEQ) taken <= alu_zero;
      if (state == PC_UPDATE) instr_count <= instr_count + CNT_W'(1);
      if (timed_out) bus_err <= 1'b1;
    end
  end

  // Next state and outputs; strobes are forced low while reset is held.
  always_comb begin
    state_nxt        = state;
    mem.MemRead      = 1'b0;
    mem.MemWrite     = 1'b0;
    mem.mem_addr_sel = 1'b0;
    RegWrite         = 1'b0;
    PCWrite          = 1'b0;
    alu_op           = ALU_ADD;
    alu_src_imm      = 1'b0;
    wb_sel           = 1'b0;
    pc_src           = 1'b0;
    illegal          = 1'b0;
    halted           = 1'b0;
    case (state)
      FETCH: begin
        mem.MemRead = 1'b1;
        if (mem.mem_ready) state_nxt = DECODE;
        else if (expired)  state_nxt = HALT;
      end
      DECODE: state_nxt = EXECUTE;
      EXECUTE: begin
        case (opcode)
          OP_ADD:  state_nxt = WRITEBACK;
          OP_NAND: begin alu_op = ALU_NAND; state_nxt = WRITEBACK; end
          OP_LW:   begin alu_src_imm = 1'b1; state_nxt = MEM_READ; end
          OP_SW:   begin alu_src_imm = 1'b1; state_nxt = MEM_WRITE; end
          OP_BEQ:  begin alu_op = ALU_SUB; state_nxt = PC_UPDATE; end
          OP_HALT: state_nxt = HALT;
          default: begin illegal = 1'b1; state_nxt = PC_UPDATE; end
        endcase
      end
      MEM_READ: begin
        mem.MemRead      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        if (mem.mem_ready) state_nxt = WRITEBACK;
        else if (expired)  state_nxt = HALT;
      end
      MEM_WRITE: begin
        mem.MemWrite     = 1'b1;
        mem.mem_addr_sel = 1'b1;
        if (mem.mem_ready) state_nxt = PC_UPDATE;
        else if (expired)  state_nxt = HALT;
      end
      WRITEBACK: begin
        RegWrite  = 1'b1;
        wb_sel    = (opcode == OP_LW);
        state_nxt = PC_UPDATE;
      end
      PC_UPDATE: begin
        PCWrite   = 1'b1;
        pc_src    = (opcode == OP_BEQ) && taken;
        state_nxt = FETCH;
      end
      HALT:    halted = 1'b1;
      default: state_nxt = FETCH;
    endcase
    if (reset) begin
      mem.MemRead  = 1'b0;
      mem.MemWrite = 1'b0;
      RegWrite     = 1'b0;
      PCWrite      = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule
